// File: rtl/uart_rx_if.sv
// Byte delivery channel from the UART receiver to its consumer.
// Latency: none, wires only.
// Backpressure: consumer holds rx_ready low to keep rx_data/rx_valid parked.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop sync, 3-sample mid-bit majority vote, 1-deep holding register.
// Latency: byte visible 9*CLKS_PER_BIT+MID+2 cycles after the FSM leaves IDLE.
// Backpressure: a byte completing while the holding register is full is dropped and sets overrun.
module uart_rx #(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      ena,
    input  logic      rx,
    uart_rx_if.master bus,
    output logic      frame_err,
    output logic      overrun,
    output logic      rx_busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int MID          = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] DECIDE   = CNT_W'(MID + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t           state;
    logic             rx_m;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             samp_a;
    logic             samp_b;
    logic [7:0]       shift;
    logic [7:0]       data_q;
    logic             valid_q;

    logic             maj;
    logic             decide;
    logic             handshake;

    assign bus.rx_data  = data_q;
    assign bus.rx_valid = valid_q;

    // Majority of the two stored samples and the live third sample, plus handshake detect.
    always_comb begin
        maj       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
        decide    = (cnt == DECIDE);
        handshake = valid_q & bus.rx_ready;
    end

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Receive FSM, bit timer, sampling and holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            samp_a    <= 1'b0;
            samp_b    <= 1'b0;
            shift     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // Consumer side works regardless of ena; a later set of overrun overrides this clear.
            if (handshake) begin
                valid_q <= 1'b0;
                overrun <= 1'b0;
            end

            if (!ena) begin
                // Disabled: throw away any partial frame silently.
                state   <= IDLE;
                cnt     <= '0;
                bit_idx <= '0;
                rx_busy <= 1'b0;
            end else begin
                if (cnt == SAMP_A) samp_a <= rx_s;
                if (cnt == SAMP_B) samp_b <= rx_s;

                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state   <= START;
                            cnt     <= '0;
                            rx_busy <= 1'b1;
                        end
                    end

                    START: begin
                        if (decide && maj) begin
                            // Line back high at mid start bit: treat as a glitch.
                            state   <= IDLE;
                            cnt     <= '0;
                            rx_busy <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (decide) shift <= {maj, shift[7:1]};
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (bit_idx == 3'd7) state <= STOP;
                            else                 bit_idx <= bit_idx + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (decide) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            if (maj) begin
                                // Leave half a bit early so the next start edge is not missed.
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                                if (!valid_q || handshake) begin
                                    data_q  <= shift;
                                    valid_q <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= RECOVER;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    RECOVER: begin
                        // Wait out a break so it reports only one framing error.
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames, glitches, framing error, overrun, abort and reset.
// Latency: DUT built with 125 clocks per bit (1.2 MHz / 9600) so each frame is 1250 cycles.
// Backpressure: rx_ready driven directly to exercise hold and overrun.
module tb_uart_rx;
    localparam int CLK_FREQ  = 1200000;
    localparam int BAUD_RATE = 9600;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;
    localparam int MID       = CPB / 2;
    localparam int LAT       = 9 * CPB + MID + 2;
    localparam int FULL      = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic rx  = 1'b1;
    logic frame_err;
    logic overrun;
    logic rx_busy;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .rx       (rx),
        .bus      (bus),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         cyc        = 0;
    int         vld_hi     = 0;
    int         hs_cnt     = 0;
    int         ferr_hi    = 0;
    int         busy_rise  = 0;
    int         valid_rise = 0;
    logic [7:0] hs_data    = 8'h00;
    logic       busy_d     = 1'b0;
    logic       valid_d    = 1'b0;

    always @(posedge clk) cyc++;

    // Observe outputs on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) vld_hi++;
        if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
            hs_cnt++;
            hs_data = bus.rx_data;
        end
        if (frame_err === 1'b1) ferr_hi++;
        if (rx_busy === 1'b1 && !busy_d) busy_rise = cyc;
        if (bus.rx_valid === 1'b1 && !valid_d) valid_rise = cyc;
        busy_d  = (rx_busy === 1'b1);
        valid_d = (bus.rx_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the first ncyc cycles of an 8N1 frame; optionally invert one cycle of one bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int gbit,
                              input int goff, input int ncyc);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            for (int t = 0; t < CPB; t++) begin
                if (j * CPB + t < ncyc) begin
                    rx = (j == gbit && t == goff) ? ~f[j] : f[j];
                    tick(1);
                end
            end
        end
        rx = 1'b1;
    endtask

    initial begin
        bus.rx_ready = 1'b1;
        tick(3);

        // Reset state
        check("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_data",  {24'd0, bus.rx_data},  32'h00);
        check("rst_ferr",  {31'd0, frame_err},    32'd0);
        check("rst_ovr",   {31'd0, overrun},      32'd0);
        check("rst_busy",  {31'd0, rx_busy},      32'd0);

        rst = 1'b0;
        ena = 1'b1;
        tick(5);

        // 0xA5 with consumer always ready
        send_frame(8'hA5, 1'b1, -1, 0, FULL);
        tick(2);
        check("a5_data",    {24'd0, hs_data},         32'hA5);
        check("a5_count",   hs_cnt,                   32'd1);
        check("a5_pulse",   vld_hi,                   32'd1);
        check("a5_latency", valid_rise - busy_rise,   LAT);
        check("a5_ferr",    ferr_hi,                  32'd0);
        check("a5_ovr",     {31'd0, overrun},         32'd0);
        check("a5_busy",    {31'd0, rx_busy},         32'd0);
        check("a5_valid",   {31'd0, bus.rx_valid},    32'd0);

        // Short low glitch on idle line: rejected at start decision
        rx = 1'b0;
        tick(24);
        rx = 1'b1;
        tick(2 * CPB);
        check("glitch_left_idle", {31'd0, busy_rise > valid_rise}, 32'd1);
        check("glitch_count",     hs_cnt,                          32'd1);
        check("glitch_busy",      {31'd0, rx_busy},                32'd0);

        // 0x00 with a one-cycle high spike hitting the centre sample of data bit 3
        send_frame(8'h00, 1'b1, 4, MID + 1, FULL);
        tick(2);
        check("vote_data",  {24'd0, hs_data}, 32'h00);
        check("vote_count", hs_cnt,           32'd2);

        // 0x3C with bad stop bit, then break for 3 bit-times, then 0x5A
        send_frame(8'h3C, 1'b0, -1, 0, FULL);
        rx = 1'b0;
        tick(3 * CPB);
        rx = 1'b1;
        tick(CPB);
        check("ferr_pulses", ferr_hi,          32'd1);
        check("ferr_nobyte", hs_cnt,           32'd2);
        check("ferr_busy",   {31'd0, rx_busy}, 32'd0);
        send_frame(8'h5A, 1'b1, -1, 0, FULL);
        tick(2);
        check("after_ferr_data",  {24'd0, hs_data}, 32'h5A);
        check("after_ferr_count", hs_cnt,           32'd3);
        check("after_ferr_ferr",  ferr_hi,          32'd1);

        // Overrun: two bytes with consumer stalled
        bus.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, -1, 0, FULL);
        send_frame(8'h22, 1'b1, -1, 0, FULL);
        tick(2);
        check("ovr_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("ovr_data",  {24'd0, bus.rx_data},  32'h11);
        check("ovr_flag",  {31'd0, overrun},      32'd1);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        check("ovr_clr_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("ovr_clr_flag",  {31'd0, overrun},      32'd0);
        check("ovr_hs_data",   {24'd0, hs_data},      32'h11);
        check("ovr_hs_count",  hs_cnt,                32'd4);

        // ena dropped during data bit 4 of 0x77, then 0xC3
        bus.rx_ready = 1'b1;
        send_frame(8'h77, 1'b1, -1, 0, 5 * CPB + MID);
        ena = 1'b0;
        rx  = 1'b1;
        tick(1);
        check("abort_busy", {31'd0, rx_busy}, 32'd0);
        tick(3);
        ena = 1'b1;
        tick(CPB);
        send_frame(8'hC3, 1'b1, -1, 0, FULL);
        tick(2);
        check("abort_data",  {24'd0, hs_data}, 32'hC3);
        check("abort_count", hs_cnt,           32'd5);
        check("abort_ferr",  ferr_hi,          32'd1);

        // Manual-mode ADD 15+10 result byte as the tile transmitter sends it
        bus.rx_ready = 1'b0;
        send_frame(8'h19, 1'b1, -1, 0, FULL);
        tick(2);
        check("sum_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("sum_data",  {24'd0, bus.rx_data},  32'h19);

        // Reset in the middle of a frame with a byte parked
        send_frame(8'hE7, 1'b1, -1, 0, 3 * CPB);
        check("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        tick(1);
        check("mrst_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("mrst_data",  {24'd0, bus.rx_data},  32'h00);
        check("mrst_busy",  {31'd0, rx_busy},      32'd0);
        check("mrst_ovr",   {31'd0, overrun},      32'd0);
        check("mrst_ferr",  {31'd0, frame_err},    32'd0);
        rst = 1'b0;
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the Jsilicon tile. It is the receive-side counterpart of the UART transmitter that drives uio_out[0] (uart_tx / uart_busy).
- Oversamples the asynchronous rx pin on the 12 MHz system clock and majority-votes each bit at mid-bit.
- Delivers bytes through a 1-deep holding register with a valid/ready handshake, and flags framing and overrun errors.
- Feeds the manual/CPU datapath as a byte source.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- CLKS_PER_BIT (derived, localparam), CLK_FREQ/BAUD_RATE = 1250, clock cycles per bit. MID = CLKS_PER_BIT/2 = 625.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  tile enable; low aborts reception.
- rx  input  1  asynchronous serial input, idles high.
- rx_data  output  8  received byte, valid while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts rx_data when rx_valid&&rx_ready.
- frame_err  output  1  one-cycle pulse on bad stop bit.
- overrun  output  1  sticky, a completed byte was dropped.
- rx_busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- One clock domain (clk). rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, rx_busy=0, FSM=IDLE, counters=0. Both synchronizer flops reset to 1.
- Synchronizer: rx passes through 2 flops to give rx_s. Only rx_s is used internally.
- Bit timer: cnt runs 0..CLKS_PER_BIT-1 within each bit. Samples are taken at cnt = MID-1, MID and MID+1. The bit decision is the majority of the 3 samples and is made at cnt = MID+1.
- FSM states:
  - IDLE: if ena && rx_s==0, go to START with cnt=0. The cycle START is entered is S.
  - START: at the decision, if majority=1 (false start/glitch), go to IDLE. Otherwise stay until cnt = CLKS_PER_BIT-1, then go to DATA with bit_idx=0.
  - DATA: the decision is shifted in LSB first. At cnt = CLKS_PER_BIT-1: if bit_idx=7 go to STOP, else bit_idx+1.
  - STOP: at the decision:
    - majority=1: commit the byte and go to IDLE immediately (half-bit early, for resync).
    - majority=0: pulse frame_err for 1 cycle, discard the byte, go to RECOVER.
  - RECOVER: stay until rx_s==1, then go to IDLE. A held-low break therefore produces exactly one frame_err.
- Latency: the commit decision is at S + 9*CLKS_PER_BIT + MID + 1. rx_valid/rx_data are visible the next cycle, S+11877 with defaults. S is 3 cycles after the first clk edge that samples rx low.
- Holding register and handshake:
  - Commit with rx_valid=0: load rx_data and set rx_valid=1.
  - rx_valid&&rx_ready (handshake): clear rx_valid next cycle.
  - Commit in the same cycle as a handshake: load new data and keep rx_valid=1. No overrun.
  - Commit with rx_valid=1 and no handshake: the new byte is dropped, rx_data is unchanged, and overrun is set.
- overrun: cleared on the cycle after a handshake. If set and clear occur in the same cycle, set wins. Reset also clears it.
- rx_data is stable while rx_valid=1 and no handshake has occurred.
- ena=0: FSM forced to IDLE and cnt/bit_idx cleared, so any partial frame is discarded. No frame_err is generated. rx_valid, rx_data and overrun are retained, and handshakes still work. Reception resumes on the next falling edge after ena=1.
- rst mid-frame: all state returns to reset values on the next edge. The partial frame is discarded.
- rx_busy = (FSM != IDLE), registered with the state.

Test Plan:
- Send 0xA5 (8N1 at 9600, 104167 ns/bit) with rx_ready=1 -> rx_valid pulses one cycle with rx_data=0xA5 at S+11877; frame_err=0, overrun=0; rx_busy low after the stop decision.
- Send a 20 us low glitch on idle rx -> FSM returns to IDLE at the start decision; rx_valid never asserts. Send a single-cycle high glitch at mid-bit of data bit 3 of 0x00 -> rx_data=0x00 (majority vote).
- Send 0x3C with stop bit driven 0, then hold low 3 bit-times, then send 0x5A -> one frame_err pulse, no rx_valid for 0x3C, then rx_data=0x5A with rx_valid=1.
- rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun=1; then rx_ready=1 for one cycle -> rx_valid=0 and overrun=0 the next cycle.
- Assert ena=0 during data bit 4 of 0x77, release, then send 0xC3 -> only 0xC3 is delivered, no frame_err. Repeat with rst=1 mid-frame -> all outputs at reset values one cycle later.
- Loopback the tile's uart_tx to rx in Manual mode, ADD 15+10 -> received byte 0x19 (25), with low byte first in the transmitter's byte order.
